// File: rtl/uart_pkg.sv
// Shared types for the UART receive controller: FSM state encoding and default byte width.
package uart_pkg;

   localparam int unsigned DATA_BITS_DEF = 8;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_IDLE    = 2'd1,
      ST_RX      = 2'd2,
      ST_RECOVER = 2'd3
   } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word, occupancy count and full flag.
module sync_fifo #(
   parameter  int unsigned DATA_BITS  = 8,
   parameter  int unsigned FIFO_DEPTH = 8,
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [DATA_BITS-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_BITS-1:0] head,
   output logic                 valid,
   output logic [CNT_W-1:0]     count,
   output logic                 full_c
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr_inc;
   logic [CNT_W-1:0]     count_nxt;
   logic [DATA_BITS-1:0] head_nxt;
   logic                 do_push;
   logic                 do_pop;

   assign full_c     = (count == CNT_W'(FIFO_DEPTH));
   assign do_pop     = pop & (count != '0);
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign do_push    = push & (~full_c | do_pop);
   assign rd_ptr_inc = rd_ptr + PTR_W'(1);
   assign count_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);

   // Next head: the following entry on pop, or the incoming word when it becomes the only entry
   always_comb begin
      head_nxt = head;
      if (do_pop) begin
         if (count > CNT_W'(1)) begin
            head_nxt = mem[rd_ptr_inc];
         end else if (do_push) begin
            head_nxt = push_data;
         end
      end else if (do_push && (count == '0)) begin
         head_nxt = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         head   <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         count <= count_nxt;
         valid <= (count_nxt != '0);
         head  <= head_nxt;
      end
   end

   // Storage needs no reset; pointers and count define which entries are live
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences a byte receiver, buffers bytes into a FIFO stream and tracks framing/overflow status.
// Optional idle timeout is built when UART_RX_IDLE_TIMEOUT_EN is defined.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter  int unsigned DATA_BITS      = DATA_BITS_DEF,
   parameter  int unsigned FIFO_DEPTH     = 8,
   parameter  int unsigned RECOVER_CYCLES = 32,
   parameter  int unsigned ERR_CNT_W      = 8,
   parameter  int unsigned IDLE_CYCLES    = 4340,
   localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_en,
   input  logic                 clr,
   output logic                 rcv_en,
   input  logic [DATA_BITS-1:0] rcv_out,
   input  logic                 rcv_done,
   input  logic                 rcv_busy,
   input  logic                 rcv_err,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 overflow,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 idle_to
);

   localparam int unsigned RC_W = $clog2(RECOVER_CYCLES + 1);

   rx_state_e        state;
   rx_state_e        state_nxt;
   logic [RC_W-1:0]  rec_cnt;
   logic             push;
   logic             err_evt;
   logic             pop_eff;
   logic             push_acc;
   logic             full_c;
   logic             drop;

   assign pop_eff  = m_valid & m_ready;
   assign push_acc = push & (~full_c | pop_eff);
   assign drop     = push & full_c & ~pop_eff;

   sync_fifo #(
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (rcv_out),
      .pop       (m_ready),
      .head      (m_data),
      .valid     (m_valid),
      .count     (fifo_count),
      .full_c    (full_c)
   );

   // Next state and capture decisions; rx_en low overrides everything
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      err_evt   = 1'b0;
      if (!rx_en) begin
         state_nxt = ST_OFF;
      end else begin
         case (state)
            ST_OFF: begin
               state_nxt = ST_IDLE;
            end
            ST_IDLE, ST_RX: begin
               if (rcv_err) begin
                  err_evt   = 1'b1;
                  state_nxt = ST_RECOVER;
               end else if (rcv_done) begin
                  push      = 1'b1;
                  state_nxt = ST_IDLE;
               end else if ((state == ST_IDLE) && rcv_busy) begin
                  state_nxt = ST_RX;
               end
            end
            ST_RECOVER: begin
               if (rec_cnt == RC_W'(RECOVER_CYCLES - 1)) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_OFF;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_OFF;
         rcv_en  <= 1'b0;
         rec_cnt <= '0;
      end else begin
         state   <= state_nxt;
         rcv_en  <= (state_nxt == ST_IDLE) || (state_nxt == ST_RX);
         if ((state == ST_RECOVER) && (state_nxt == ST_RECOVER)) begin
            rec_cnt <= rec_cnt + RC_W'(1);
         end else begin
            rec_cnt <= '0;
         end
      end
   end

   // Status: a set event in the same cycle as clr takes precedence
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         err_count <= '0;
      end else begin
         overflow <= drop | (overflow & ~clr);
         if (err_evt) begin
            if (clr) begin
               err_count <= ERR_CNT_W'(1);
            end else if (err_count != '1) begin
               err_count <= err_count + ERR_CNT_W'(1);
            end
         end else if (clr) begin
            err_count <= '0;
         end
      end
   end

`ifdef UART_RX_IDLE_TIMEOUT_EN
   localparam int unsigned IT_W = $clog2(IDLE_CYCLES + 1);

   logic [IT_W-1:0] idle_cnt;
   logic            idle_run;
   logic            idle_hit;

   // Counts unread idle time; any stream activity or leaving IDLE restarts it
   assign idle_run = (state == ST_IDLE) && (state_nxt == ST_IDLE) && m_valid
                     && !push_acc && !pop_eff;
   assign idle_hit = idle_run && (idle_cnt == IT_W'(IDLE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
         idle_to  <= 1'b0;
      end else begin
         if (!idle_run) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IT_W'(IDLE_CYCLES)) begin
            idle_cnt <= idle_cnt + IT_W'(1);
         end
         idle_to <= idle_hit | (idle_to & ~clr);
      end
   end
`else
   logic unused_idle_cfg;

   assign unused_idle_cfg = (IDLE_CYCLES != 0);
   assign idle_to         = 1'b0;
`endif

endmodule
